vid_pixel_readback: RTL and testbench
=====================================

Name: vid_pixel_readback

Overview:
- Memory-mapped read path from video memory back to the processor; counterpart of the image/font placement write path.
- Processor writes X/Y registers and issues a read command. Block computes the linear address, drives the video memory read port, captures the 6-bit pixel, and returns it on the databus.
- Optional auto-increment walks the frame for streaming readback.
- Sits beside the placement logic on the display databus; owns a second read port of the 6-bit video memory.

Parameters:
- BASE, 16'hC00B, first register address: BASE+0 X, BASE+1 Y, BASE+2 CMD/STATUS, BASE+3 PIXEL.
- RD_LAT, 1, video memory read latency in clk cycles (1..4).
- H_PIX, 640, pixels per line.
- V_PIX, 480, lines per frame.

Ports:
- clk  in  1  system clock (50MHz domain)
- rst_n  in  1  asynchronous active-low reset
- rb_sel  in  1  bus select for this block's address window
- addr  in  16  processor bus address
- bus_we  in  1  write strobe (one cycle)
- bus_re  in  1  read strobe (one cycle)
- databus  in  16  processor write data
- rb_rdata  out  16  read data; 0 when not addressed (OR-able onto bus)
- vm_raddr  out  19  video memory read address
- vm_re  out  1  video memory read enable
- vm_rdata  in  6  video memory read data, {R[1:0],G[1:0],B[1:0]}

Behaviour:
- Reset: X=0, Y=0, autoinc=0, pixel=0, valid=0, busy=0, err=0, state IDLE; vm_re=0, vm_raddr=0, rb_rdata=0.
- Register writes (rb_sel & bus_we & address match):
  - BASE+0: X<=databus[9:0].
  - BASE+1: Y<=databus[8:0].
  - BASE+2: bit0 = start, bit1 = autoinc (latched on every CMD write).
- Start handling:
  - Accepted only in IDLE. Start while busy is ignored; autoinc is still updated.
  - If X>=H_PIX or Y>=V_PIX at start: err<=1, no fetch, valid unchanged.
  - Otherwise: err<=0, valid<=0, busy<=1, go to ISSUE.
- Address arithmetic: vm_raddr = (Y<<9)+(Y<<7)+X, 19 bits unsigned (Y*640+X). Computed combinationally from the X/Y registers and held stable through ISSUE/WAIT.
- FSM:
  - IDLE: on accepted start -> ISSUE.
  - ISSUE: vm_re=1 for exactly one cycle -> WAIT, counter=RD_LAT-1.
  - WAIT: decrement the counter each cycle. When it reaches 0, pixel<=vm_rdata, valid<=1, busy<=0 -> IDLE.
  - For RD_LAT=1, WAIT lasts one cycle.
- Latency: CMD write in cycle T -> vm_re high in T+1 -> valid visible at T+2+RD_LAT (T+3 at default).
- Reads (combinational, rb_sel & bus_re & address match, else 0):
  - BASE+2: {13'b0, err, busy, valid}.
  - BASE+3: {valid, 9'b0, pixel}.
  - BASE+0 / BASE+1: zero-extended X / Y.
- PIXEL read side effect:
  - Any BASE+3 read with valid=1 clears valid next cycle.
  - If autoinc=1, it also advances X and auto-starts a new fetch (IDLE->ISSUE next cycle).
- Wrap rules:
  - X==H_PIX-1: X<=0, Y<=Y+1.
  - X==H_PIX-1 and Y==V_PIX-1: X<=0, Y<=0.
  - Auto-start after a wrap never flags err.
- PIXEL read with valid=0: returns the stale pixel with bit15=0; no state change.
- Writes to X/Y while busy: register updates immediately, but vm_raddr for the in-flight fetch is held from a copy latched on entry to ISSUE.
- Reset asserted mid-fetch: immediate return to IDLE with all reset values. A late vm_rdata is ignored.
- Writes and reads to BASE+0..3 without rb_sel: no effect.

Test Plan:
- Write X=5, Y=2, CMD=1 at T; memory word 1285 preloaded 6'h2D -> vm_raddr=1285, vm_re pulse at T+1, STATUS=3'b001 at T+3, PIXEL read=16'h802D, next STATUS valid=0.
- X=639, Y=479, CMD=3 (autoinc), word 307199=6'h3F, word 0=6'h01 -> first PIXEL read 16'h803F. Then X=0, Y=0 auto-fetch; second PIXEL read 16'h8001.
- X=640, CMD=1 -> STATUS=3'b100, no vm_re pulse. Then X=0, CMD=1 -> err cleared, fetch proceeds.
- CMD=1 issued, second CMD=1 in the next cycle while busy -> exactly one vm_re pulse; X write during WAIT does not alter the captured address.
- Assert rst_n low in WAIT cycle -> rb_rdata=0, STATUS=0, vm_re=0. After release, no spurious valid when vm_rdata changes.
- RD_LAT=3 build, X=1, Y=1, CMD=1 at T -> vm_raddr=641, valid at T+5, pixel equals the word 641 contents.

Source files
------------

// File: rtl/vid_pixel_readback_if.sv
// vid_pixel_readback_if: processor databus window plus the second video memory read port
interface vid_pixel_readback_if;
  logic        rb_sel;
  logic [15:0] addr;
  logic        bus_we;
  logic        bus_re;
  logic [15:0] databus;
  logic [15:0] rb_rdata;
  logic [18:0] vm_raddr;
  logic        vm_re;
  logic [5:0]  vm_rdata;
  modport slave (input rb_sel, addr, bus_we, bus_re, databus, vm_rdata, output rb_rdata, vm_raddr, vm_re);
  modport master (output rb_sel, addr, bus_we, bus_re, databus, vm_rdata, input rb_rdata, vm_raddr, vm_re);
endinterface

// File: rtl/vid_pixel_readback.sv
// vid_pixel_readback: fetches one 6-bit pixel at (X,Y) from video memory and returns it on the databus
module vid_pixel_readback #(
  parameter logic [15:0] BASE   = 16'hC00B,
  parameter int          RD_LAT = 1,
  parameter int          H_PIX  = 640,
  parameter int          V_PIX  = 480
) (
  input logic clk,
  input logic rst_n,
  vid_pixel_readback_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [9:0]  X_LAST   = 10'(H_PIX - 1);
  localparam logic [8:0]  Y_LAST   = 9'(V_PIX - 1);
  localparam logic [1:0]  CNT_INIT = 2'(RD_LAT - 1);
  localparam logic [15:0] A_Y = BASE + 16'd1;
  localparam logic [15:0] A_C = BASE + 16'd2;
  localparam logic [15:0] A_P = BASE + 16'd3;
  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [18:0] addr_q, addr_d;
  logic [5:0]  pix_q, pix_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        autoinc_q, autoinc_d, valid_q, valid_d, err_q, err_d;
  logic        wr, rd, cmd_wr, pix_rd, adv, go, in_range, busy;
  logic        unused_hi;
  function automatic logic [18:0] lin(input logic [9:0] x, input logic [8:0] y);
    return (19'(y) << 9) + (19'(y) << 7) + 19'(x);
  endfunction
  assign unused_hi = ^bus.databus[15:10];
  assign wr       = bus.rb_sel & bus.bus_we;
  assign rd       = bus.rb_sel & bus.bus_re;
  assign busy     = state_q != IDLE;
  assign cmd_wr   = wr && bus.addr == A_C;
  assign pix_rd   = rd && bus.addr == A_P && valid_q;
  assign adv      = pix_rd & autoinc_q;
  assign go       = !busy && ((cmd_wr && bus.databus[0]) || adv);
  assign in_range = x_d <= X_LAST && y_d <= Y_LAST;
  // auto-increment walks the frame in raster order and wraps to (0,0)
  assign x_d = (wr && bus.addr == BASE) ? bus.databus[9:0] :
               adv ? (x_q == X_LAST ? '0 : x_q + 10'd1) : x_q;
  assign y_d = (wr && bus.addr == A_Y) ? bus.databus[8:0] :
               (adv && x_q == X_LAST) ? (y_q == Y_LAST ? '0 : y_q + 9'd1) : y_q;
  assign autoinc_d = cmd_wr ? bus.databus[1] : autoinc_q;
  always_comb begin
    state_d = state_q;
    valid_d = valid_q & ~pix_rd;
    err_d   = err_q;
    addr_d  = addr_q;
    pix_d   = pix_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (go) begin
        if (in_range) begin
          state_d = ISSUE;
          valid_d = 1'b0;
          err_d   = 1'b0;
          addr_d  = lin(x_d, y_d);
        end else err_d = 1'b1;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_INIT;
      end
      WAIT: if (cnt_q == 2'd0) begin
        state_d = IDLE;
        pix_d   = bus.vm_rdata;
        valid_d = 1'b1;
      end else cnt_d = cnt_q - 2'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      pix_q     <= '0;
      cnt_q     <= '0;
      autoinc_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      pix_q     <= pix_d;
      cnt_q     <= cnt_d;
      autoinc_q <= autoinc_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end
  // in-flight fetches use the address captured at start so X/Y rewrites cannot disturb them
  assign bus.vm_re    = state_q == ISSUE;
  assign bus.vm_raddr = busy ? addr_q : lin(x_q, y_q);
  assign bus.rb_rdata = !rd                ? '0 :
                        bus.addr == BASE   ? {6'b0, x_q} :
                        bus.addr == A_Y    ? {7'b0, y_q} :
                        bus.addr == A_C    ? {13'b0, err_q, busy, valid_q} :
                        bus.addr == A_P    ? {valid_q, 9'b0, pix_q} : '0;
endmodule

// File: tb/tb_vid_pixel_readback.sv
// tb_vid_pixel_readback: scoreboard bench for the pixel readback path at RD_LAT 1 and 3
module tb_vid_pixel_readback;
  localparam logic [15:0] BASE = 16'hC00B;
  localparam logic [15:0] A_X = BASE;
  localparam logic [15:0] A_Y = BASE + 16'd1;
  localparam logic [15:0] A_C = BASE + 16'd2;
  localparam logic [15:0] A_P = BASE + 16'd3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;
  vid_pixel_readback_if b1();
  vid_pixel_readback_if b3();
  logic [5:0]  mem [0:307199];
  logic [5:0]  m1, m3a, m3b, m3c;
  logic [18:0] aq1[$], aq3[$];
  logic [5:0]  pq[$];
  int checks = 0, failures = 0;
  int pushes1 = 0, pushes3 = 0, pulses1 = 0, pulses3 = 0;
  assign b1.vm_rdata = m1;
  assign b3.vm_rdata = m3c;
  vid_pixel_readback #(.BASE(BASE), .RD_LAT(1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(b1));
  vid_pixel_readback #(.BASE(BASE), .RD_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  // memory models return garbage whenever no read was issued
  always @(posedge clk) begin
    m1  <= b1.vm_re ? mem[b1.vm_raddr] : 6'($urandom);
    m3a <= b3.vm_re ? mem[b3.vm_raddr] : 6'($urandom);
    m3b <= m3a;
    m3c <= m3b;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (b1.vm_re) begin
    pulses1++;
    if (aq1.size() != 0) chk("vm_raddr1", 32'(b1.vm_raddr), 32'(aq1.pop_front()));
    else chk("vm_re1_unexpected", 32'(b1.vm_re), 0);
  end
  always @(negedge clk) if (b3.vm_re) begin
    pulses3++;
    if (aq3.size() != 0) chk("vm_raddr3", 32'(b3.vm_raddr), 32'(aq3.pop_front()));
    else chk("vm_re3_unexpected", 32'(b3.vm_re), 0);
  end
  task automatic drive(input int t, input logic we, input logic re, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    b1.rb_sel = (t == 0);
    b3.rb_sel = (t == 1);
    b1.bus_we = we;
    b3.bus_we = we;
    b1.bus_re = re;
    b3.bus_re = re;
    b1.addr = a;
    b3.addr = a;
    b1.databus = d;
    b3.databus = d;
  endtask
  task automatic wr(input int t, input logic [15:0] a, input logic [15:0] d);
    drive(t, 1'b1, 1'b0, a, d);
  endtask
  task automatic rd(input int t, input logic [15:0] a, output logic [15:0] r);
    drive(t, 1'b0, 1'b1, a, 16'd0);
    #1 r = (t == 1) ? b3.rb_rdata : b1.rb_rdata;
  endtask
  task automatic expect_fetch(input int t, input logic [9:0] x, input logic [8:0] y);
    int a;
    a = int'(y) * 640 + int'(x);
    if (t == 1) begin
      aq3.push_back(19'(a));
      pushes3++;
    end else begin
      aq1.push_back(19'(a));
      pushes1++;
    end
    pq.push_back(mem[a]);
  endtask
  task automatic start(input int t, input logic [9:0] x, input logic [8:0] y, input logic [15:0] cmd);
    wr(t, A_X, 16'(x));
    wr(t, A_Y, 16'(y));
    expect_fetch(t, x, y);
    wr(t, A_C, cmd);
  endtask
  task automatic wait_valid(input int t);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 20; i++) begin
      rd(t, A_C, r);
      if (r[0]) break;
    end
    chk("wait_valid", 32'(r[0]), 1);
  endtask
  task automatic pix_read(input int t, input string tag);
    logic [15:0] r, e;
    rd(t, A_P, r);
    e = {1'b1, 9'b0, pq.pop_front()};
    chk(tag, 32'(r), 32'(e));
  endtask
  initial begin
    logic [15:0] r;
    b1.rb_sel = 0; b1.bus_we = 0; b1.bus_re = 0; b1.addr = 0; b1.databus = 0;
    b3.rb_sel = 0; b3.bus_we = 0; b3.bus_re = 0; b3.addr = 0; b3.databus = 0;
    for (int i = 0; i < 307200; i++) mem[i] = 6'(i * 7 + 3);
    mem[1285] = 6'h2D;
    mem[307199] = 6'h3F;
    mem[0] = 6'h01;
    repeat (3) @(negedge clk);
    rd(0, A_C, r); chk("rst_status", 32'(r), 0);
    rd(0, A_X, r); chk("rst_x", 32'(r), 0);
    chk("rst_vm_re", 32'(b1.vm_re), 0);
    chk("rst_vm_raddr", 32'(b1.vm_raddr), 0);
    drive(2, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(2, 0, 0, 0, 0);
    start(0, 10'd5, 9'd2, 16'd1);
    rd(0, A_C, r); chk("t1_issue_status", 32'(r), 2); chk("t1_vm_re", 32'(b1.vm_re), 1);
    rd(0, A_C, r); chk("t1_wait_status", 32'(r), 2); chk("t1_vm_re_off", 32'(b1.vm_re), 0);
    rd(0, A_C, r); chk("t1_valid_status", 32'(r), 1);
    rd(0, A_P, r); chk("t1_pixel", 32'(r), 32'h802D); void'(pq.pop_front());
    rd(0, A_C, r); chk("t1_valid_cleared", 32'(r), 0);
    wr(2, A_X, 16'd77);
    rd(0, A_X, r); chk("nosel_x_kept", 32'(r), 5);
    rd(2, A_X, r); chk("nosel_rdata", 32'(r), 0);
    start(0, 10'd639, 9'd479, 16'd3);
    wait_valid(0);
    rd(0, A_P, r); chk("t2_pixel_last", 32'(r), 32'h803F); void'(pq.pop_front());
    expect_fetch(0, 10'd0, 9'd0);
    rd(0, A_X, r); chk("t2_x_wrap", 32'(r), 0);
    rd(0, A_Y, r); chk("t2_y_wrap", 32'(r), 0);
    wait_valid(0);
    rd(0, A_P, r); chk("t2_pixel_first", 32'(r), 32'h8001); void'(pq.pop_front());
    expect_fetch(0, 10'd1, 9'd0);
    wr(0, A_C, 16'd0);
    rd(0, A_C, r); chk("t2_no_err", 32'(r[2]), 0);
    wait_valid(0);
    pix_read(0, "t2_pixel_next");
    rd(0, A_X, r); chk("t2_x_adv", 32'(r), 1);
    wr(0, A_X, 16'd640);
    wr(0, A_C, 16'd1);
    rd(0, A_C, r); chk("t3_err_status", 32'(r), 4);
    start(0, 10'd0, 9'd0, 16'd1);
    rd(0, A_C, r); chk("t3_err_cleared", 32'(r), 2);
    wait_valid(0);
    pix_read(0, "t3_pixel");
    start(1, 10'd10, 9'd3, 16'd1);
    wr(1, A_C, 16'd1);
    wr(1, A_X, 16'd20);
    rd(1, A_C, r); chk("t4_busy", 32'(r), 2);
    chk("t4_addr_held", 32'(b3.vm_raddr), 1930);
    wait_valid(1);
    pix_read(1, "t4_pixel");
    rd(1, A_X, r); chk("t4_x_updated", 32'(r), 20);
    start(0, 10'd3, 9'd4, 16'd1);
    void'(pq.pop_back());
    drive(2, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("t5_vm_re", 32'(b1.vm_re), 0);
    rd(0, A_C, r); chk("t5_status", 32'(r), 0);
    rd(0, A_P, r); chk("t5_pixel", 32'(r), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rd(0, A_C, r); chk("t5_no_valid", 32'(r), 0);
    end
    start(1, 10'd1, 9'd1, 16'd1);
    for (int i = 0; i < 4; i++) begin
      rd(1, A_C, r); chk("t6_busy", 32'(r), 2);
    end
    rd(1, A_C, r); chk("t6_valid", 32'(r), 1);
    pix_read(1, "t6_pixel");
    drive(2, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("re_count1", 32'(pulses1), 32'(pushes1));
    chk("re_count3", 32'(pulses3), 32'(pushes3));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
